mul_iter: RTL and testbench

Parametrised multi-cycle integer multiplier for the execute stage. It produces the full 2·WIDTH-bit product as HI/LO halves for MULT/MULTU, where the existing combinational unit only yields the low 32 bits. It processes STEP multiplier bits per cycle through a WIDTH×STEP partial-product step, and supports signed and unsigned modes. A start/ready/valid handshake and a pipeline flush connect it to the stall logic.

---
 rtl/mul_iter_pkg.sv | 29 ++
 rtl/mul_step.sv | 22 ++
 rtl/mul_iter.sv | 140 ++++++++++++++
 tb/tb_mul_iter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg
//   Shared definitions for the iterative multiplier: the FSM state
//   encoding, the CYCLES / counter-width derivations and the parameter
//   legality check used by mul_iter at elaboration time.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to consume the whole multiplier.
  function automatic int calc_cycles(input int width, input int step);
    return width / step;
  endfunction

  // Iteration counter width; a single-cycle build still needs one bit.
  function automatic int calc_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // WIDTH must be even and at least 4, and STEP must divide it exactly.
  function automatic bit params_ok(input int width, input int step);
    return (width >= 4) && (width % 2 == 0) &&
           (step > 0) && (step <= width) && (width % step == 0);
  endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step
//   Purely combinational unsigned WIDTH x STEP partial product.
//   Ports:
//     a  in  WIDTH        multiplicand (unsigned)
//     b  in  STEP         multiplier slice (unsigned)
//     p  out WIDTH+STEP   full product a*b
module mul_step
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 16
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [STEP-1:0]       b,
  output logic [WIDTH+STEP-1:0] p
);

  // Both operands are zero-extended to the product width so the
  // multiply is unsigned and no product bits are lost.
  assign p = {{STEP{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mul_iter.sv
// mul_iter
//   Multi-cycle signed/unsigned integer multiplier producing the full
//   2*WIDTH-bit product as hi/lo halves. STEP multiplier bits are consumed
//   per cycle, so a result takes WIDTH/STEP RUN cycles plus one DONE cycle.
//   Ports:
//     clk        in   sole clock, rising edge
//     resetn     in   synchronous active-low reset
//     start      in   request, accepted when ready=1
//     is_signed  in   1 = two's-complement operands, 0 = unsigned
//     a, b       in   multiplicand / multiplier, sampled with start
//     flush      in   abort any operation, overrides start
//     ready      out  unit can accept start this cycle
//     valid      out  one-cycle pulse, hi/lo hold a new result
//     hi, lo     out  upper / lower half of the product
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CYCLES = calc_cycles(WIDTH, STEP);
  localparam int CNT_W  = calc_cnt_w(CYCLES);
  localparam int W2     = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  if (!params_ok(WIDTH, STEP)) begin : g_param_check
    $error("mul_iter: WIDTH must be even and >= 4, and STEP must divide WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic             neg;
  logic [W2-1:0]    acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]      abs_a;
  logic [WIDTH-1:0]      abs_b;
  logic                  neg_in;
  logic [31:0]           shamt;
  logic [STEP-1:0]       b_slice;
  logic [WIDTH+STEP-1:0] pp;
  logic [W2-1:0]         pp_ext;
  logic [W2-1:0]         acc_sum;
  logic [W2-1:0]         result;

  // Magnitudes are multiplied unsigned and the sign is reapplied at the
  // end. Negating 0x80..0 wraps back to 0x80..0, which is the correct
  // magnitude when read as unsigned, so no special case is required.
  assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  // Select the multiplier slice for this iteration and weight its partial
  // product by the same bit offset.
  assign shamt   = 32'(cnt) * 32'(STEP);
  assign b_slice = STEP'(ub >> shamt);

  mul_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .a(ua),
    .b(b_slice),
    .p(pp)
  );

  assign pp_ext  = W2'(pp) << shamt;
  assign acc_sum = acc + pp_ext;
  assign result  = neg ? -acc_sum : acc_sum;

  assign ready = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ua    <= '0;
      ub    <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        // hi/lo are deliberately left alone so the last good result stays visible.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            // DONE accepts a new request just like IDLE for back-to-back use.
            if (start) begin
              ua    <= abs_a;
              ub    <= abs_b;
              neg   <= neg_in;
              acc   <= '0;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          RUN: begin
            acc <= acc_sum;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= DONE;
              valid <= 1'b1;
              hi    <= result[W2-1:WIDTH];
              lo    <= result[WIDTH-1:0];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter
//   Scoreboard bench for mul_iter. Three builds (STEP 16, 8 and 1) share
//   clock, reset, flush and operands but have their own start line. The
//   stimulus side pushes the expected product and due cycle into a
//   per-build queue; independent monitors pop and compare whenever a
//   build raises valid.
module tb_mul_iter;

  localparam int W     = 32;
  localparam int LAT16 = 3;
  localparam int LAT8  = 5;
  localparam int LAT1  = 33;
  localparam int N_RANDOM = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         start16, start8, start1;
  logic         ready16, ready8, ready1;
  logic         valid16, valid8, valid1;
  logic [W-1:0] hi16, lo16, hi8, lo8, hi1, lo1;

  int cyc = 0;
  int n_vectors = 0;
  int n_miscompares = 0;

  exp_t q16[$];
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  // Counts rising edges; used to check result latency.
  always @(posedge clk) cyc <= cyc + 1;

  mul_iter #(.WIDTH(W), .STEP(16)) dut16 (
    .clk(clk), .resetn(resetn), .start(start16), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .ready(ready16), .valid(valid16),
    .hi(hi16), .lo(lo16)
  );

  mul_iter #(.WIDTH(W), .STEP(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .ready(ready8), .valid(valid8),
    .hi(hi8), .lo(lo8)
  );

  mul_iter #(.WIDTH(W), .STEP(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .ready(ready1), .valid(valid1),
    .hi(hi1), .lo(lo1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer multiplication of the operands.
  function automatic logic [63:0] ref_product(input logic s, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic ready_sel(input int which);
    case (which)
      0:       return ready16;
      1:       return ready8;
      default: return ready1;
    endcase
  endfunction

  // Waits (bounded) for the selected build to be ready, issues one
  // request and records the expected result and its due cycle.
  task automatic applyStimulus(input int which, input logic s, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [63:0] expected);
    exp_t e;
    int   guard;
    logic rdy;
    guard = 0;
    @(negedge clk);
    rdy = ready_sel(which);
    while (!rdy && guard < 200) begin
      @(negedge clk);
      rdy = ready_sel(which);
      guard++;
    end
    if (!rdy) begin
      checkOutput("ready timeout", 64'(rdy), 64'd1);
      return;
    end
    is_signed = s;
    a         = av;
    b         = bv;
    e.prod    = expected;
    case (which)
      0: begin start16 = 1'b1; e.due = cyc + LAT16; q16.push_back(e); end
      1: begin start8  = 1'b1; e.due = cyc + LAT8;  q8.push_back(e);  end
      default: begin start1 = 1'b1; e.due = cyc + LAT1; q1.push_back(e); end
    endcase
    @(negedge clk);
    start16 = 1'b0;
    start8  = 1'b0;
    start1  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q16.size() + q8.size() + q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drain", 64'(q16.size() + q8.size() + q1.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitors: any valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (valid16) begin
      if (q16.size() == 0) begin
        checkOutput("dut16 unexpected valid", 64'(valid16), 64'd0);
      end else begin
        e = q16.pop_front();
        checkOutput("dut16 product", {hi16, lo16}, e.prod);
        checkOutput("dut16 latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid8) begin
      if (q8.size() == 0) begin
        checkOutput("dut8 unexpected valid", 64'(valid8), 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("dut8 product", {hi8, lo8}, e.prod);
        checkOutput("dut8 latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1 unexpected valid", 64'(valid1), 64'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1 product", {hi1, lo1}, e.prod);
        checkOutput("dut1 latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t         e;
    logic         s;
    logic [W-1:0] av, bv;

    resetn    = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    start16   = 1'b0;
    start8    = 1'b0;
    start1    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 64'(ready16), 64'd1);
    checkOutput("reset valid", 64'(valid16), 64'd0);
    checkOutput("reset hi/lo", {hi16, lo16}, 64'd0);
    checkOutput("reset hi/lo step1", {hi1, lo1}, 64'd0);
    resetn = 1'b1;

    // Directed products on the STEP=16 build.
    applyStimulus(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    applyStimulus(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
    wait_drain(100);

    // Flush in the first RUN cycle of 7x9: no result, previous one kept.
    is_signed = 1'b0;
    a         = 32'd7;
    b         = 32'd9;
    start16   = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("ready after flush", 64'(ready16), 64'd1);
    checkOutput("hi/lo held after flush", {hi16, lo16}, 64'h0000_0001_0000_0000);

    // A start coincident with flush must be ignored.
    flush   = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    start16 = 1'b0;
    checkOutput("start ignored under flush", 64'(ready16), 64'd1);
    repeat (5) @(negedge clk);

    applyStimulus(0, 1'b0, 32'd2, 32'd3, 64'd6);
    wait_drain(100);

    // Back-to-back: start held high across 3x4 then 5x6.
    is_signed = 1'b0;
    a         = 32'd3;
    b         = 32'd4;
    start16   = 1'b1;
    e.prod = 64'd12;
    e.due  = cyc + LAT16;
    q16.push_back(e);
    e.prod = 64'd30;
    e.due  = cyc + 2 * LAT16;
    q16.push_back(e);
    @(negedge clk);
    a = 32'd5;
    b = 32'd6;
    repeat (3) @(negedge clk);
    start16 = 1'b0;
    wait_drain(100);

    // Reset in the middle of RUN: outputs cleared, no result.
    is_signed = 1'b1;
    a         = 32'hFFFF_FFFB;
    b         = 32'd7;
    start16   = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    resetn  = 1'b0;
    @(negedge clk);
    checkOutput("mid-run reset hi/lo", {hi16, lo16}, 64'd0);
    checkOutput("mid-run reset valid", 64'(valid16), 64'd0);
    checkOutput("mid-run reset ready", 64'(ready16), 64'd1);
    checkOutput("mid-run reset hi/lo step8", {hi8, lo8}, 64'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Random operands on every build.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N_RANDOM; i++) begin
        s  = 1'($urandom_range(0, 1));
        av = pick_operand();
        bv = pick_operand();
        applyStimulus(k, s, av, bv, ref_product(s, av, bv));
      end
    end
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
